// File: rtl/writeback_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_unit_pkg
//  Description : Shared writeback state and source-select encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package writeback_unit_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

    typedef enum logic [1:0] {
        SRC_IMM = 2'd0,
        SRC_MEM = 2'd1,
        SRC_ALU = 2'd2
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/writeback_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_unit_if
//  Description : Retire-side handshake, memory return and register-file write bus.
//  Revision    : 1.0 - initial release
// ============================================================================
interface writeback_unit_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic              use_imm;
    logic              mem_read;
    logic              reg_write;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] alu_result;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              busy;
    logic              load_timeout;

    modport master (
        output in_valid, use_imm, mem_read, reg_write, rd, imm_ext, alu_result,
               mem_rvalid, mem_rdata,
        input  in_ready, wb_en, wb_addr, wb_data, busy, load_timeout
    );

    modport slave (
        input  in_valid, use_imm, mem_read, reg_write, rd, imm_ext, alu_result,
               mem_rvalid, mem_rdata,
        output in_ready, wb_en, wb_addr, wb_data, busy, load_timeout
    );
endinterface
`default_nettype wire

// File: rtl/wb_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_timeout_counter
//  Description : Saturating load-wait counter with an expiry flag at TIMEOUT-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout_counter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clear,
    input  wire logic             i_inc,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_expired
);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_MAX  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    // Clear wins over increment; the count saturates instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_expired = (r_count == c_LAST);
endmodule
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_unit
//  Description : Retire-stage writeback with immediate/ALU/load sources and load timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    writeback_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    wb_state_e         r_state;
    logic              r_wb_en;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_load_timeout;
    logic [ADDR_W-1:0] r_rd;
    logic              r_reg_write;

    logic              w_xfer;
    wb_src_e           w_src;
    logic              w_cnt_clear;
    logic              w_cnt_inc;
    logic              w_expired;
    logic [CNT_W-1:0]  w_count;

    assign w_xfer = bus.in_valid && (r_state == IDLE);

    // Immediate beats load, load beats ALU.
    always_comb begin
        w_src = SRC_ALU;
        if (bus.use_imm) begin
            w_src = SRC_IMM;
        end else if (bus.mem_read) begin
            w_src = SRC_MEM;
        end
    end

    assign w_cnt_clear = w_xfer && (w_src == SRC_MEM);
    assign w_cnt_inc   = (r_state == WAIT_MEM) && !bus.mem_rvalid;

    wb_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_counter (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_cnt_clear),
        .i_inc     (w_cnt_inc),
        .o_count   (w_count),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_wb_en        <= 1'b0;
            r_wb_addr      <= '0;
            r_wb_data      <= '0;
            r_load_timeout <= 1'b0;
            r_rd           <= '0;
            r_reg_write    <= 1'b0;
        end else begin
            r_wb_en        <= 1'b0;
            r_load_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        case (w_src)
                            SRC_MEM: begin
                                r_rd        <= bus.rd;
                                r_reg_write <= bus.reg_write;
                                r_state     <= WAIT_MEM;
                            end
                            SRC_IMM: begin
                                r_wb_en   <= bus.reg_write;
                                r_wb_addr <= bus.rd;
                                r_wb_data <= bus.imm_ext;
                            end
                            default: begin
                                r_wb_en   <= bus.reg_write;
                                r_wb_addr <= bus.rd;
                                r_wb_data <= bus.alu_result;
                            end
                        endcase
                    end
                end
                WAIT_MEM: begin
                    // Returning data takes precedence over an expiring count.
                    if (bus.mem_rvalid) begin
                        r_wb_en   <= r_reg_write;
                        r_wb_addr <= r_rd;
                        r_wb_data <= bus.mem_rdata;
                        r_state   <= IDLE;
                    end else if (w_expired) begin
                        r_load_timeout <= 1'b1;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = (r_state == IDLE);
    assign bus.busy         = (r_state == WAIT_MEM);
    assign bus.wb_en        = r_wb_en;
    assign bus.wb_addr      = r_wb_addr;
    assign bus.wb_data      = r_wb_data;
    assign bus.load_timeout = r_load_timeout;

    logic w_unused;
    assign w_unused = ^w_count;
endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_unit
//  Description : Directed self-checking bench for writeback_unit (TIMEOUT=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_unit;
    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 2;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    writeback_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    writeback_unit #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.use_imm    = 1'b0;
        bus.mem_read   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.rd         = '0;
        bus.imm_ext    = '0;
        bus.alu_result = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic present(input logic imm, input logic mrd, input logic rw,
                           input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] iv,
                           input logic [DATA_W-1:0] av);
        bus.in_valid   = 1'b1;
        bus.use_imm    = imm;
        bus.mem_read   = mrd;
        bus.reg_write  = rw;
        bus.rd         = r;
        bus.imm_ext    = iv;
        bus.alu_result = av;
    endtask

    initial begin
        idle_inputs();
        #2;
        chk("rst_wb_en",   32'(bus.wb_en), 0);
        chk("rst_wb_addr", 32'(bus.wb_addr), 0);
        chk("rst_wb_data", 32'(bus.wb_data), 0);
        chk("rst_timeout", 32'(bus.load_timeout), 0);
        chk("rst_busy",    32'(bus.busy), 0);
        tick();
        tick();
        rst = 1'b0;
        chk("ready_after_rst", 32'(bus.in_ready), 1);

        // ALU write
        present(1'b0, 1'b0, 1'b1, 2'd2, 8'h00, 8'h5A);
        tick();
        chk("alu_wb_en",   32'(bus.wb_en), 1);
        chk("alu_wb_addr", 32'(bus.wb_addr), 2);
        chk("alu_wb_data", 32'(bus.wb_data), 32'h5A);

        // Back-to-back ALU write
        present(1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 8'h33);
        tick();
        chk("b2b_wb_en",   32'(bus.wb_en), 1);
        chk("b2b_wb_addr", 32'(bus.wb_addr), 3);
        chk("b2b_wb_data", 32'(bus.wb_data), 32'h33);
        idle_inputs();
        tick();
        chk("idle_wb_en",   32'(bus.wb_en), 0);
        chk("idle_wb_data", 32'(bus.wb_data), 32'h33);

        // Immediate overrides load
        present(1'b1, 1'b1, 1'b1, 2'd0, 8'h11, 8'hFF);
        tick();
        chk("prio_wb_en",   32'(bus.wb_en), 1);
        chk("prio_wb_data", 32'(bus.wb_data), 32'h11);
        chk("prio_busy",    32'(bus.busy), 0);
        chk("prio_ready",   32'(bus.in_ready), 1);

        // reg_write=0 gives no strobe
        present(1'b0, 1'b0, 1'b0, 2'd1, 8'h00, 8'h44);
        tick();
        chk("norw_wb_en", 32'(bus.wb_en), 0);
        idle_inputs();

        // Load, data three cycles after transfer; rvalid on transfer cycle is ignored
        present(1'b0, 1'b1, 1'b1, 2'd1, 8'h00, 8'h00);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 8'hEE;
        tick();
        idle_inputs();
        chk("ld_busy1",  32'(bus.busy), 1);
        chk("ld_ready1", 32'(bus.in_ready), 0);
        chk("ld_wb_en1", 32'(bus.wb_en), 0);
        tick();
        chk("ld_ready2", 32'(bus.in_ready), 0);
        tick();
        chk("ld_ready3", 32'(bus.in_ready), 0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 8'hC3;
        tick();
        idle_inputs();
        chk("ld_wb_en",   32'(bus.wb_en), 1);
        chk("ld_wb_addr", 32'(bus.wb_addr), 1);
        chk("ld_wb_data", 32'(bus.wb_data), 32'hC3);
        chk("ld_ready",   32'(bus.in_ready), 1);
        tick();
        chk("ld_wb_en_after", 32'(bus.wb_en), 0);

        // Timeout: TIMEOUT wait cycles with counter 0..TIMEOUT-1, then the pulse
        present(1'b0, 1'b1, 1'b1, 2'd3, 8'h00, 8'h00);
        tick();
        idle_inputs();
        chk("to_busy_w1", 32'(bus.busy), 1);
        for (int i = 2; i <= TIMEOUT; i++) begin
            tick();
            chk($sformatf("to_busy_w%0d", i), 32'(bus.busy), 1);
            chk($sformatf("to_nopulse_w%0d", i), 32'(bus.load_timeout), 0);
        end
        tick();
        chk("to_pulse",  32'(bus.load_timeout), 1);
        chk("to_wb_en",  32'(bus.wb_en), 0);
        chk("to_busy",   32'(bus.busy), 0);
        chk("to_ready",  32'(bus.in_ready), 1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 8'h77;
        tick();
        idle_inputs();
        chk("late_wb_en",   32'(bus.wb_en), 0);
        chk("late_pulse",   32'(bus.load_timeout), 0);
        chk("late_wb_data", 32'(bus.wb_data), 32'hC3);

        // Data arriving with counter at TIMEOUT-1 wins
        present(1'b0, 1'b1, 1'b1, 2'd2, 8'h00, 8'h00);
        tick();
        idle_inputs();
        for (int i = 2; i <= TIMEOUT; i++) tick();
        chk("bnd_busy", 32'(bus.busy), 1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 8'hA5;
        tick();
        idle_inputs();
        chk("bnd_wb_en",   32'(bus.wb_en), 1);
        chk("bnd_wb_addr", 32'(bus.wb_addr), 2);
        chk("bnd_wb_data", 32'(bus.wb_data), 32'hA5);
        chk("bnd_pulse",   32'(bus.load_timeout), 0);
        tick();
        chk("bnd_pulse_after", 32'(bus.load_timeout), 0);

        // Reset mid-wait
        present(1'b0, 1'b1, 1'b1, 2'd1, 8'h00, 8'h00);
        tick();
        idle_inputs();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_wb_en",   32'(bus.wb_en), 0);
        chk("mrst_wb_addr", 32'(bus.wb_addr), 0);
        chk("mrst_wb_data", 32'(bus.wb_data), 0);
        chk("mrst_busy",    32'(bus.busy), 0);
        chk("mrst_pulse",   32'(bus.load_timeout), 0);
        tick();
        rst = 1'b0;
        chk("mrst_ready", 32'(bus.in_ready), 1);
        for (int i = 0; i < TIMEOUT + 2; i++) begin
            tick();
            chk($sformatf("mrst_quiet%0d", i), 32'({bus.load_timeout, bus.wb_en}), 0);
        end
        present(1'b1, 1'b0, 1'b1, 2'd3, 8'h9C, 8'h00);
        tick();
        idle_inputs();
        chk("post_rst_wb_data", 32'(bus.wb_data), 32'h9C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
